// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator arbiter.
// State encoding, result bit positions and default sizes.
package cmp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COMPARE = 2'd1,
      ST_RESPOND = 2'd2
   } state_e;

   localparam int GT_BIT = 0;
   localparam int EQ_BIT = 1;
   localparam int LT_BIT = 2;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set request at or after ptr_i, wrapping.
// Produces a one-hot grant and its binary index.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] idx_o
);

   int   cand;
   logic found;

   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      cand    = 0;
      for (int k = 0; k < N; k++) begin
         cand = (int'(ptr_i) + k) % N;
         if (!found && req_i[cand]) begin
            found         = 1'b1;
            grant_o[cand] = 1'b1;
            idx_o         = IW'(cand);
         end
      end
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin shared comparator: IDLE -> COMPARE -> RESPOND.
// Define CMP_ARBITER_SIGNED_EN for two's-complement comparison.
module cmp_arbiter
   import cmp_pkg::*;
#(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int IW      = $clog2(NUM_REQ)
) (
   input  logic                      iClk,
   input  logic                      iRstN,
   input  logic [NUM_REQ-1:0]        iReqValid,
   output logic [NUM_REQ-1:0]        oReqReady,
   input  logic [NUM_REQ*DATA_W-1:0] iReqA,
   input  logic [NUM_REQ*DATA_W-1:0] iReqB,
   output logic                      oRspValid,
   input  logic                      iRspReady,
   output logic [2:0]                oRspData,
   output logic [IW-1:0]             oRspId,
   output logic                      oBusy
);

   state_e              state_q, state_d;
   logic [IW-1:0]       ptr_q, ptr_d;
   logic [IW-1:0]       id_q, id_d;
   logic [DATA_W-1:0]   a_q, a_d;
   logic [DATA_W-1:0]   b_q, b_d;
   logic [2:0]          rsp_q, rsp_d;
   logic [NUM_REQ-1:0]  grant;
   logic [IW-1:0]       gnt_idx;
   logic                take;
   logic                a_gt, a_lt, a_eq;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (IW)
   ) u_rr (
      .req_i   (iReqValid),
      .ptr_i   (ptr_q),
      .grant_o (grant),
      .idx_o   (gnt_idx)
   );

   assign take = (state_q == ST_IDLE) && (|iReqValid);

`ifdef CMP_ARBITER_SIGNED_EN
   assign a_gt = $signed(a_q) > $signed(b_q);
   assign a_lt = $signed(a_q) < $signed(b_q);
`else
   assign a_gt = a_q > b_q;
   assign a_lt = a_q < b_q;
`endif
   assign a_eq = a_q == b_q;

   always_ff @(posedge iClk) begin
      if (!iRstN) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         id_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         rsp_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         id_q    <= id_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rsp_q   <= rsp_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (|iReqValid) state_d = ST_COMPARE;
         ST_COMPARE: state_d = ST_RESPOND;
         ST_RESPOND: if (iRspReady) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Operands are captured at grant so a dropped request cannot disturb them.
   always_comb begin
      ptr_d = ptr_q;
      id_d  = id_q;
      a_d   = a_q;
      b_d   = b_q;
      rsp_d = rsp_q;
      if (take) begin
         a_d   = iReqA[gnt_idx*DATA_W +: DATA_W];
         b_d   = iReqB[gnt_idx*DATA_W +: DATA_W];
         id_d  = gnt_idx;
         ptr_d = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (state_q == ST_COMPARE) begin
         rsp_d         = '0;
         rsp_d[GT_BIT] = a_gt;
         rsp_d[EQ_BIT] = a_eq;
         rsp_d[LT_BIT] = a_lt;
      end
   end

   always_comb begin
      oReqReady = '0;
      oRspValid = 1'b0;
      oBusy     = 1'b0;
      case (state_q)
         ST_IDLE: if (iRstN) oReqReady = grant;
         ST_COMPARE: oBusy = 1'b1;
         ST_RESPOND: begin
            oBusy     = 1'b1;
            oRspValid = 1'b1;
         end
         default: oBusy = 1'b1;
      endcase
   end

   assign oRspData = rsp_q;
   assign oRspId   = id_q;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter with hand-computed expectations.
// Honours CMP_ARBITER_SIGNED_EN for the signed-mode vectors.
module tb_cmp_arbiter;

   localparam int NR = 4;
   localparam int DW = 32;

   logic             clk;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [2:0]       rsp_data;
   logic [1:0]       rsp_id;
   logic             busy;

   int nvec;
   int nerr;

   cmp_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
      .iClk      (clk),
      .iRstN     (rst_n),
      .iReqValid (req_valid),
      .oReqReady (req_ready),
      .iReqA     (req_a),
      .iReqB     (req_b),
      .oRspValid (rsp_valid),
      .iRspReady (rsp_ready),
      .oRspData  (rsp_data),
      .oRspId    (rsp_id),
      .oBusy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a,
                         input logic [31:0] b);
      req_a[i*DW +: DW] = a;
      req_b[i*DW +: DW] = b;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      req_a     = '0;
      req_b     = '0;
      tick();
      tick();
      req_valid = 4'b1111;
      #1;
      nvec++;
      if (req_ready !== 4'b0000) begin
         nerr++;
         $display("FAIL reset_ready got %b want 0000", req_ready);
      end
      nvec++;
      if ({rsp_valid, rsp_data, rsp_id, busy} !== 7'b0) begin
         nerr++;
         $display("FAIL reset_outs got v=%b d=%b id=%0d b=%b want 0",
                  rsp_valid, rsp_data, rsp_id, busy);
      end
      req_valid = '0;
      rst_n     = 1'b1;
      tick();
   endtask

   task automatic test_single();
      set_op(0, 32'd5, 32'd3);
      req_valid = 4'b0001;
      #1;
      nvec++;
      if (req_ready !== 4'b0001 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL single_grant got rdy=%b busy=%b want 0001/0",
                  req_ready, busy);
      end
      tick();
      req_valid = '0;
      set_op(0, 32'd0, 32'd9);
      #1;
      nvec++;
      if (req_ready !== 4'b0 || busy !== 1'b1 || rsp_valid !== 1'b0) begin
         nerr++;
         $display("FAIL single_cmp got rdy=%b busy=%b v=%b want 0000/1/0",
                  req_ready, busy, rsp_valid);
      end
      tick();
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 3'b001 || rsp_id !== 2'd0) begin
         nerr++;
         $display("FAIL single_rsp got v=%b d=%b id=%0d want 1/001/0",
                  rsp_valid, rsp_data, rsp_id);
      end
      tick();
      nvec++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         nerr++;
         $display("FAIL single_idle got v=%b busy=%b want 0/0",
                  rsp_valid, busy);
      end
   endtask

   task automatic test_equal();
      set_op(2, 32'hDEADBEEF, 32'hDEADBEEF);
      req_valid = 4'b0100;
      #1;
      nvec++;
      if (req_ready !== 4'b0100) begin
         nerr++;
         $display("FAIL equal_grant got %b want 0100", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      nvec++;
      if (rsp_valid !== 1'b1 || rsp_data !== 3'b010 || rsp_id !== 2'd2) begin
         nerr++;
         $display("FAIL equal_rsp got v=%b d=%b id=%0d want 1/010/2",
                  rsp_valid, rsp_data, rsp_id);
      end
      tick();
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_d [4];
      int         order [5];
      int         w;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      set_op(0, 32'd1, 32'd2);
      set_op(1, 32'd7, 32'd7);
      set_op(2, 32'd9, 32'd4);
      set_op(3, 32'h80000000, 32'd1);
      exp_d[0] = 3'b100;
      exp_d[1] = 3'b010;
      exp_d[2] = 3'b001;
`ifdef CMP_ARBITER_SIGNED_EN
      exp_d[3] = 3'b100;
`else
      exp_d[3] = 3'b001;
`endif
      order = '{0, 1, 2, 3, 0};
      rsp_ready = 1'b1;
      req_valid = 4'b1111;
      #1;
      for (int g = 0; g < 5; g++) begin
         w = order[g];
         nvec++;
         if (req_ready !== 4'(1 << w)) begin
            nerr++;
            $display("FAIL rr_grant%0d got %b want idx %0d",
                     g, req_ready, w);
         end
         tick();
         nvec++;
         if (req_ready !== 4'b0000) begin
            nerr++;
            $display("FAIL rr_cmp%0d got rdy=%b want 0000", g, req_ready);
         end
         tick();
         nvec++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'(w) ||
             rsp_data !== exp_d[w]) begin
            nerr++;
            $display("FAIL rr_rsp%0d got v=%b id=%0d d=%b want 1/%0d/%b",
                     g, rsp_valid, rsp_id, rsp_data, w, exp_d[w]);
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      // Pointer sits at 1 after the last round-robin grant to 0.
      rsp_ready = 1'b0;
      req_valid = 4'b1111;
      #1;
      nvec++;
      if (req_ready !== 4'b0010) begin
         nerr++;
         $display("FAIL bp_grant got %b want 0010", req_ready);
      end
      tick();
      tick();
      for (int c = 0; c < 5; c++) begin
         nvec++;
         if (rsp_valid !== 1'b1 || rsp_data !== 3'b010 ||
             rsp_id !== 2'd1 || req_ready !== 4'b0) begin
            nerr++;
            $display("FAIL bp_hold%0d got v=%b d=%b id=%0d rdy=%b",
                     c, rsp_valid, rsp_data, rsp_id, req_ready);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      nvec++;
      if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
         nerr++;
         $display("FAIL bp_release got v=%b rdy=%b want 0/0100",
                  rsp_valid, req_ready);
      end
      req_valid = '0;
      tick();
   endtask

   task automatic test_signed();
      set_op(3, 32'hFFFFFFFF, 32'd1);
      req_valid = 4'b1000;
      #1;
      nvec++;
      if (req_ready !== 4'b1000) begin
         nerr++;
         $display("FAIL sgn_grant got %b want 1000", req_ready);
      end
      tick();
      req_valid = '0;
      tick();
      nvec++;
`ifdef CMP_ARBITER_SIGNED_EN
      if (rsp_data !== 3'b100 || rsp_id !== 2'd3) begin
         nerr++;
         $display("FAIL sgn_rsp got d=%b id=%0d want 100/3",
                  rsp_data, rsp_id);
      end
`else
      if (rsp_data !== 3'b001 || rsp_id !== 2'd3) begin
         nerr++;
         $display("FAIL sgn_rsp got d=%b id=%0d want 001/3",
                  rsp_data, rsp_id);
      end
`endif
      tick();
   endtask

   task automatic test_reset_mid();
      set_op(1, 32'd5, 32'd3);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      nvec++;
      if (busy !== 1'b1) begin
         nerr++;
         $display("FAIL mid_busy got %b want 1", busy);
      end
      rst_n = 1'b0;
      tick();
      nvec++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0 ||
          rsp_data !== 3'b000 || rsp_id !== 2'd0) begin
         nerr++;
         $display("FAIL mid_abort got v=%b b=%b d=%b id=%0d want 0",
                  rsp_valid, busy, rsp_data, rsp_id);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         nvec++;
         if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            nerr++;
            $display("FAIL mid_stale%0d got v=%b busy=%b want 0/0",
                     c, rsp_valid, busy);
         end
      end
      req_valid = 4'b1110;
      #1;
      nvec++;
      if (req_ready !== 4'b0010) begin
         nerr++;
         $display("FAIL mid_ptr got %b want 0010", req_ready);
      end
      req_valid = '0;
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      test_reset();
      test_single();
      test_equal();
      test_round_robin();
      test_back_to_back();
      test_signed();
      test_reset_mid();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
